// File: rtl/lane_merge4.sv
// lane_merge4: four valid/ready lanes merged round-robin into one lane-tagged output stream
module lane_merge4 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_lane,
  input  logic               out_ready,
  output logic               busy
);
  logic [3:0]       full;
  logic [WIDTH-1:0] buf_data [4];
  logic [1:0]       ptr, gnt;
  logic             has, load;
  assign in_ready = {4{rst_n}} & ~full;
  assign load     = ~out_valid | out_ready;
  assign busy     = |full | out_valid;
  always_comb begin
    gnt = 2'd0;
    has = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      gnt = full[ptr + 2'(k)] ? ptr + 2'(k) : gnt;
      has = has | full[ptr + 2'(k)];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lane  <= '0;
      for (int i = 0; i < 4; i++) buf_data[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          full[i]     <= 1'b1;
          buf_data[i] <= in_data[i*WIDTH +: WIDTH];
        end
      end
      if (load) begin
        out_valid <= has;
        if (has) begin
          out_data  <= buf_data[gnt];
          out_lane  <= gnt;
          full[gnt] <= 1'b0;
          ptr       <= gnt + 2'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_lane_merge4.sv
// tb_lane_merge4: directed self-checking bench for lane_merge4 (WIDTH=1)
module tb_lane_merge4;
  logic       clk, rst_n, out_ready, out_valid, busy;
  logic [3:0] in_valid, in_data, in_ready;
  logic [0:0] out_data;
  logic [1:0] out_lane;
  int total = 0, bad = 0;
  lane_merge4 #(.WIDTH(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_lane(out_lane), .out_ready(out_ready), .busy(busy)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string tag, input logic v, input logic d, input logic [1:0] l);
    chk({tag, ".valid"}, out_valid, v);
    chk({tag, ".data"}, out_data, d);
    chk({tag, ".lane"}, out_lane, l);
  endtask
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst.in_ready", in_ready, 4'b0000);
    chk("rst.valid", out_valid, 1'b0);
    chk("rst.busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
  endtask
  initial begin
    rst_n = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("r0.in_ready", in_ready, 4'b0000);
    chk_out("r0", 1'b0, 1'b0, 2'd0);
    chk("r0.busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("r1.in_ready", in_ready, 4'b1111);
    in_valid = 4'b0100; in_data = 4'b0100;
    tick();
    in_valid = '0;
    chk("s0.in_ready", in_ready, 4'b1011);
    chk("s0.valid", out_valid, 1'b0);
    chk("s0.busy", busy, 1'b1);
    tick();
    chk_out("s1", 1'b1, 1'b1, 2'd2);
    chk("s1.in_ready", in_ready, 4'b1111);
    tick();
    chk("s2.valid", out_valid, 1'b0);
    chk("s2.busy", busy, 1'b0);
    pulse_reset();
    in_valid = 4'b1111; in_data = 4'b1101;
    tick();
    in_valid = '0;
    chk("f0.in_ready", in_ready, 4'b0000);
    tick(); chk_out("f1", 1'b1, 1'b1, 2'd0);
    tick(); chk_out("f2", 1'b1, 1'b0, 2'd1);
    tick(); chk_out("f3", 1'b1, 1'b1, 2'd2);
    tick(); chk_out("f4", 1'b1, 1'b1, 2'd3);
    tick(); chk("f5.valid", out_valid, 1'b0);
    out_ready = 1'b0; in_valid = 4'b1111; in_data = 4'b1010;
    tick();
    in_data = 4'b1011;
    chk("b1.in_ready", in_ready, 4'b0000);
    tick();
    chk_out("b2", 1'b1, 1'b0, 2'd0);
    chk("b2.in_ready", in_ready, 4'b0001);
    for (int c = 3; c <= 5; c++) begin
      tick();
      chk_out($sformatf("b%0d", c), 1'b1, 1'b0, 2'd0);
      chk($sformatf("b%0d.in_ready", c), in_ready, 4'b0000);
      chk($sformatf("b%0d.busy", c), busy, 1'b1);
    end
    in_valid = '0; out_ready = 1'b1;
    tick(); chk_out("c1", 1'b1, 1'b1, 2'd1);
    tick(); chk_out("c2", 1'b1, 1'b0, 2'd2);
    tick(); chk_out("c3", 1'b1, 1'b1, 2'd3);
    tick(); chk_out("c4", 1'b1, 1'b1, 2'd0);
    tick(); chk("c5.valid", out_valid, 1'b0);
    chk("c5.busy", busy, 1'b0);
    in_valid = 4'b1001; in_data = 4'b0001;
    tick();
    chk("d1.in_ready", in_ready, 4'b0110);
    tick(); chk_out("d2", 1'b1, 1'b0, 2'd3); chk("d2.in_ready", in_ready, 4'b1110);
    tick(); chk_out("d3", 1'b1, 1'b1, 2'd0); chk("d3.in_ready", in_ready, 4'b0111);
    tick(); chk_out("d4", 1'b1, 1'b0, 2'd3); chk("d4.in_ready", in_ready, 4'b1110);
    tick(); chk_out("d5", 1'b1, 1'b1, 2'd0); chk("d5.in_ready", in_ready, 4'b0111);
    in_valid = '0;
    tick(); chk_out("d6", 1'b1, 1'b0, 2'd3);
    tick(); chk("d7.valid", out_valid, 1'b0);
    out_ready = 1'b0; in_valid = 4'b1111; in_data = 4'b1111;
    tick(); tick(); tick();
    chk("e0.valid", out_valid, 1'b1);
    chk("e0.in_ready", in_ready, 4'b0000);
    chk("e0.busy", busy, 1'b1);
    in_valid = '0; out_ready = 1'b1;
    pulse_reset();
    chk("e1.in_ready", in_ready, 4'b1111);
    chk_out("e1", 1'b0, 1'b0, 2'd0);
    in_valid = 4'b0010; in_data = 4'b0010;
    tick();
    in_valid = '0;
    chk("e2.valid", out_valid, 1'b0);
    tick(); chk_out("e3", 1'b1, 1'b1, 2'd1);
    tick(); chk("e4.busy", busy, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
